// File: rtl/led_pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_pkg                                                          |
// | Shared types and constants for the LED/GPIO PWM output bank.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package led_pwm_pkg;

  // Config storage is sized for the widest supported duty/period; narrower
  // instances zero-extend into it.
  localparam int CFG_DUTY_W   = 16;
  localparam int CFG_PERIOD_W = 16;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e                   mode;
    logic [CFG_DUTY_W-1:0]   duty;
    logic [CFG_PERIOD_W-1:0] period;
  } ch_cfg_t;

  localparam ch_cfg_t CFG_RESET = '{mode: MODE_DIRECT, duty: '0, period: '0};

endpackage
`default_nettype wire

// File: rtl/led_pwm_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_bank_if                                                      |
// | Valid/ready channel-configuration write port.                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface led_pwm_bank_if #(
  parameter int CH_W    = 3,
  parameter int PWM_W   = 8,
  parameter int BLINK_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_mode;
  logic [PWM_W-1:0]   cfg_duty;
  logic [BLINK_W-1:0] cfg_period;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_period,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_period,
    output cfg_ready, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/led_pwm_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_ch                                                           |
// | One output channel: active config, blink/breathe state, compare.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_pwm_ch
  import led_pwm_pkg::*;
#(
  parameter int PWM_W   = 8,
  parameter int BLINK_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             apply_i,
  input  ch_cfg_t          cfg_i,
  input  logic             boundary_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             gpio_i,
  output logic             raw_o
);

  localparam logic [PWM_W-1:0] LVL_TOP_M1 = {PWM_W{1'b1}} - 1'b1;

  ch_cfg_t            cfg_q;
  logic [BLINK_W-1:0] fcnt_q;
  logic               phase_q;
  logic [PWM_W-1:0]   level_q;
  logic               dir_down_q;
  logic               wrap;
  logic               duty_hit;

  assign wrap     = (CFG_PERIOD_W'(fcnt_q) == cfg_q.period);
  assign duty_hit = (CFG_DUTY_W'(pwm_cnt_i) < cfg_q.duty);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cfg_q      <= CFG_RESET;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
      level_q    <= '0;
      dir_down_q <= 1'b0;
    end else if (apply_i) begin
      cfg_q      <= cfg_i;
      fcnt_q     <= '0;
      phase_q    <= 1'b1;
      level_q    <= '0;
      dir_down_q <= 1'b0;
    end else if (boundary_i) begin
      if (wrap) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
        // Triangle sweep: turn around one step before each end is reached.
        if (dir_down_q) begin
          level_q <= level_q - 1'b1;
          if (level_q == {{(PWM_W-1){1'b0}}, 1'b1}) dir_down_q <= 1'b0;
        end else begin
          level_q <= level_q + 1'b1;
          if (level_q == LVL_TOP_M1) dir_down_q <= 1'b1;
        end
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    raw_o = 1'b0;
    case (cfg_q.mode)
      MODE_DIRECT:  raw_o = gpio_i;
      MODE_PWM:     raw_o = duty_hit;
      MODE_BLINK:   raw_o = phase_q && duty_hit;
      MODE_BREATHE: raw_o = (pwm_cnt_i < level_q);
      default:      raw_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/led_pwm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_bank                                                         |
// | N-channel LED driver: prescaler, frame counter, shadowed config.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 16,
  parameter int BLINK_W = 8
) (
  input  logic               clk_50MHz,
  input  logic               arst_n,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [N_CH-1:0]    gpio_write,
  led_pwm_bank_if.slave      cfg,
  output logic               frame_sync,
  output logic [N_CH-1:0]    leds
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic               pend_valid_q, pend_valid_d;
  logic [CH_W-1:0]    pend_ch_q, pend_ch_d;
  ch_cfg_t            pend_cfg_q, pend_cfg_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               frame_sync_q;
  logic [N_CH-1:0]    leds_q;
  logic [N_CH-1:0]    raw;
  logic               tick, boundary, accept, ch_bad, apply;

  always_comb begin
    tick       = (pcnt_q >= prescale);
    boundary   = tick && (pwm_cnt_q == {PWM_W{1'b1}});
    accept     = cfg.cfg_valid && ready_q;
    ch_bad     = (int'(cfg.cfg_ch) >= N_CH);
    apply      = boundary && pend_valid_q;
    pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    err_d      = accept && ch_bad;

    pend_valid_d = pend_valid_q;
    pend_ch_d    = pend_ch_q;
    pend_cfg_d   = pend_cfg_q;
    // Out-of-range writes are swallowed without touching the slot.
    if (accept && !ch_bad) begin
      pend_valid_d = 1'b1;
      pend_ch_d    = cfg.cfg_ch;
      pend_cfg_d   = '{mode:   mode_e'(cfg.cfg_mode),
                       duty:   CFG_DUTY_W'(cfg.cfg_duty),
                       period: CFG_PERIOD_W'(cfg.cfg_period)};
    end else if (apply) begin
      pend_valid_d = 1'b0;
    end
    ready_d = !pend_valid_d;
  end

  always_ff @(posedge clk_50MHz or negedge arst_n) begin
    if (!arst_n) begin
      pcnt_q       <= '0;
      pwm_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_cfg_q   <= CFG_RESET;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      frame_sync_q <= 1'b0;
      leds_q       <= '0;
    end else begin
      pcnt_q       <= pcnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_ch_q    <= pend_ch_d;
      pend_cfg_q   <= pend_cfg_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      frame_sync_q <= boundary;
      leds_q       <= raw;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    led_pwm_ch #(
      .PWM_W   (PWM_W),
      .BLINK_W (BLINK_W)
    ) u_ch (
      .clk_i      (clk_50MHz),
      .arst_ni    (arst_n),
      .apply_i    (apply && (pend_ch_q == CH_W'(gi))),
      .cfg_i      (pend_cfg_q),
      .boundary_i (boundary),
      .pwm_cnt_i  (pwm_cnt_q),
      .gpio_i     (gpio_write[gi]),
      .raw_o      (raw[gi])
    );
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign frame_sync    = frame_sync_q;
  assign leds          = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_pwm_bank                                                      |
// | Randomised scoreboard bench against a frame-arithmetic model.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_led_pwm_bank;

  localparam int N   = 6;
  localparam int PW  = 7;
  localparam int PSW = 16;
  localparam int BW  = 8;
  localparam int CHW = 3;
  localparam int M   = 1 << PW;

  logic           clk = 1'b0;
  logic           arst_n;
  logic [PSW-1:0] prescale;
  logic [N-1:0]   gpio;
  logic           gpio_rand;
  logic           frame_sync;
  logic [N-1:0]   leds;

  int vectors = 0;
  int miscompares = 0;

  led_pwm_bank_if #(.CH_W(CHW), .PWM_W(PW), .BLINK_W(BW)) cfg_bus ();

  led_pwm_bank #(
    .N_CH    (N),
    .PWM_W   (PW),
    .PRESC_W (PSW),
    .BLINK_W (BW)
  ) dut (
    .clk_50MHz  (clk),
    .arst_n     (arst_n),
    .prescale   (prescale),
    .gpio_write (gpio),
    .cfg        (cfg_bus),
    .frame_sync (frame_sync),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  // Reference model: output = f(ticks since reset, frames since each apply).
  logic [N+2:0] exp_q[$];
  int  k;
  bit  m_pend, m_rdy;
  int  m_mode[N], m_duty[N], m_per[N], m_applyF[N];
  int  p_mode, p_duty, p_per, p_ch;

  always @(posedge clk) begin : model
    int p, t, pwm, f, fs, s, lvl;
    logic tick, bnd, acc, err;
    logic [N-1:0] el;
    if (!arst_n) begin
      k = 0; m_pend = 0; m_rdy = 0;
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0; m_duty[i] = 0; m_per[i] = 0; m_applyF[i] = 0;
      end
      exp_q.push_back('0);
    end else begin
      p    = int'(prescale);
      t    = k / (p + 1);
      tick = (k % (p + 1)) == p;
      pwm  = t % M;
      f    = t / M;
      bnd  = tick && (pwm == M - 1);
      for (int i = 0; i < N; i++) begin
        fs = f - m_applyF[i];
        case (m_mode[i])
          0: el[i] = gpio[i];
          1: el[i] = pwm < m_duty[i];
          2: el[i] = (((fs / (m_per[i] + 1)) % 2) == 0) && (pwm < m_duty[i]);
          default: begin
            s     = (fs / (m_per[i] + 1)) % (2 * (M - 1));
            lvl   = (s <= M - 1) ? s : 2 * (M - 1) - s;
            el[i] = pwm < lvl;
          end
        endcase
      end
      acc = cfg_bus.cfg_valid && m_rdy;
      err = acc && (int'(cfg_bus.cfg_ch) >= N);
      if (bnd && m_pend) begin
        m_mode[p_ch] = p_mode; m_duty[p_ch] = p_duty; m_per[p_ch] = p_per;
        m_applyF[p_ch] = f + 1;
        m_pend = 0;
      end
      if (acc && !err) begin
        m_pend = 1;
        p_ch   = int'(cfg_bus.cfg_ch);
        p_mode = int'(cfg_bus.cfg_mode);
        p_duty = int'(cfg_bus.cfg_duty);
        p_per  = int'(cfg_bus.cfg_period);
      end
      m_rdy = !m_pend;
      exp_q.push_back({el, bnd, m_rdy, err});
      k++;
    end
  end

  always @(negedge clk) begin : monitor
    logic [N+2:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {leds, frame_sync, cfg_bus.cfg_ready, cfg_bus.cfg_err};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got leds=%h fs=%b rdy=%b err=%b, expected leds=%h fs=%b rdy=%b err=%b",
                 $time, g[N+2:3], g[2], g[1], g[0], e[N+2:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin : gpio_drv
    forever begin
      @(negedge clk);
      #1;
      if (gpio_rand) gpio = N'($urandom);
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input int ch, input int mode, input int duty, input int per);
    int waited = 0;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_ch     = CHW'(ch);
    cfg_bus.cfg_mode   = 2'(mode);
    cfg_bus.cfg_duty   = PW'(duty);
    cfg_bus.cfg_period = BW'(per);
    while (!cfg_bus.cfg_ready) begin
      run(1);
      waited++;
      if (waited > 4 * M * (int'(prescale) + 1) + 16) begin
        vectors++;
        miscompares++;
        $display("FAIL cfg_write_timeout: ch=%0d got cfg_ready=0 after %0d cycles, expected 1", ch, waited);
        cfg_bus.cfg_valid = 1'b0;
        return;
      end
    end
    run(1);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic do_reset(input int presc);
    arst_n   = 1'b0;
    prescale = PSW'(presc);
    run(3);
    arst_n = 1'b1;
  endtask

  initial begin : stim
    arst_n             = 1'b0;
    prescale           = '0;
    gpio               = N'(6'h25);
    gpio_rand          = 1'b0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_ch     = '0;
    cfg_bus.cfg_mode   = '0;
    cfg_bus.cfg_duty   = '0;
    cfg_bus.cfg_period = '0;
    run(3);
    arst_n = 1'b1;
    run(4);
    gpio = N'(6'h1A);
    run(3);
    gpio_rand = 1'b1;
    run(8);

    cfg_write(2, 1, 64, 0);
    run(3 * M);

    cfg_write(0, 2, M - 1, 1);
    run(6 * M);

    cfg_write(1, 3, 0, 0);
    run((M + 4) * M);

    cfg_write(3, 1, 10, 0);
    cfg_write(4, 1, 100, 0);
    cfg_write(6 + int'($urandom_range(0, 1)), 1, 50, 0);
    run(2 * M);

    // Pending write in flight when reset hits mid-breathe.
    cfg_write(5, 2, 30, 0);
    arst_n = 1'b0;
    #1;
    vectors++;
    if (leds !== '0 || frame_sync !== 1'b0 || cfg_bus.cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got leds=%h fs=%b rdy=%b, expected leds=0 fs=0 rdy=0",
               leds, frame_sync, cfg_bus.cfg_ready);
    end
    run(3);
    arst_n = 1'b1;
    run(2 * M);

    do_reset(int'($urandom_range(1, 3)));
    for (int w = 0; w < 16; w++) begin
      cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, M - 1)), int'($urandom_range(0, 2)));
      run(int'($urandom_range(0, 2 * M)));
    end
    run(2 * M);

    run(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pwm_bank.md
# led_pwm_bank

Parametrised LED/GPIO output driver: the next-generation replacement for wiring the SoC GPIO write bus straight onto the board LEDs. Each of N_CH channels independently runs in DIRECT, PWM, BLINK or BREATHE mode, configured through a valid/ready write port. It sits between the SoC GPIO output and the `leds` pins at board top level. Configuration changes are shadowed and applied only at PWM frame boundaries, so updates are glitch-free.

## Interface
- `N_CH`, 8: channel count, 1..32.
- `PWM_W`, 8: PWM counter/duty width; frame = 2^PWM_W ticks.
- `PRESC_W`, 16: prescaler width.
- `BLINK_W`, 8: blink/breathe period width.
- `CH_W`, derived: `$clog2(N_CH)`, minimum 1.

Ports:
- `clk_50MHz`  in  1  sole clock.
- `arst_n`  in  1  reset; asynchronous, active-low.
- `prescale`  in  PRESC_W  tick divider; tick every prescale+1 cycles.
- `gpio_write`  in  N_CH  DIRECT-mode source from SoC GPIO.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config slot free.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_mode`  in  2  0 DIRECT, 1 PWM, 2 BLINK, 3 BREATHE.
- `cfg_duty`  in  PWM_W  PWM duty; BLINK on-level duty.
- `cfg_period`  in  BLINK_W  frames per BLINK toggle / BREATHE step, minus 1.
- `cfg_err`  out  1  one-cycle pulse: write to cfg_ch >= N_CH.
- `frame_sync`  out  1  one-cycle pulse at each frame boundary.
- `leds`  out  N_CH  registered outputs.

## Operation
- Prescaler `pcnt`: tick when `pcnt >= prescale`, then `pcnt <= 0`; otherwise increment. `prescale=0` ticks every cycle. Lowering `prescale` mid-count takes effect immediately.
- `pwm_cnt` (PWM_W bits) increments on tick and wraps at 2^PWM_W-1 to 0. A frame boundary is a tick with `pwm_cnt == 2^PWM_W-1`.
- Config handshake: transfer on `cfg_valid && cfg_ready`. The accepted write loads a single pending slot and `cfg_ready` drops. At the next frame boundary the pending entry is written to that channel's active config and its channel state is cleared. `cfg_ready` rises the following cycle. A write accepted in a frame-boundary cycle waits for the next boundary.
- If `cfg_ch >= N_CH`: the write is accepted, nothing is stored, `cfg_err` pulses the next cycle, and `cfg_ready` stays 1.
- Per-channel raw output:
  - DIRECT: `gpio_write[i]`.
  - PWM: `pwm_cnt < duty`. Duty 0 is always off; max duty is high for 2^PWM_W-1 of 2^PWM_W ticks.
  - BLINK: `fcnt` counts frame boundaries. When `fcnt == period`, `fcnt <= 0` and the `phase` bit toggles. Output is `phase && (pwm_cnt < duty)`. After apply, `phase=1` and `fcnt=0`.
  - BREATHE: on `fcnt == period`, `level` steps ±1. `dir` flips when `level` reaches 2^PWM_W-1 (next value max-1) or 0 (next value 1). Output is `pwm_cnt < level`. After apply, `level=0` and direction is up.
- `leds[i]` is the raw output registered: one-cycle latency from inputs and counters.

## Timing
- Reset (async assert) values:
  - `leds=0`, `cfg_ready=0`, `cfg_err=0`, `frame_sync=0`.
  - All counters 0.
  - All channels DIRECT with duty 0, period 0.
- `cfg_ready` goes to 1 on the first clock after reset deassertion.
- Reset mid-operation drops any pending write and returns all channels to DIRECT.
- `frame_sync` is registered, so it is high the cycle after the boundary tick.
- Frame length = 2^PWM_W × (prescale+1) cycles.
- Apply latency: from 1 cycle (accept just before a boundary) to one full frame.

## Structure
- `led_pwm_pkg`: `mode_e` enum (DIRECT/PWM/BLINK/BREATHE), `ch_cfg_t` struct {mode, duty, period}, reset config constant.
- Sub-module `led_pwm_ch`: per-channel active config, fcnt/phase/level/dir, and output compare. Generated N_CH times.
- The top level holds the prescaler, `pwm_cnt`, pending slot, handshake, and output register.

## Test plan
- Reset with `gpio_write=8'hA5`, all channels DIRECT -> `leds=0` during reset, `leds=8'hA5` one cycle after the first post-reset edge; `gpio_write` change visible after 1 cycle.
- `prescale=0`, write ch2 PWM with duty 64 -> after the next boundary, `leds[2]` is high for exactly 64 of every 256 cycles, aligned to `frame_sync`.
- Write ch0 BLINK with duty 255, period 1, `prescale=0` -> `phase` toggles every 2 frames (512 cycles); on-phase shows 255/256 duty.
- Write ch1 BREATHE with period 0 -> `level` is 0,1,…,255,254,… per frame; peak after 255 frames.
- Two back-to-back writes -> second is held (`cfg_ready=0`) until the first boundary applies, `cfg_ready=1` one cycle later; a write to `cfg_ch=8` with N_CH=8 gives a `cfg_err` pulse and no change.
- Assert `arst_n` mid-BREATHE -> `leds=0` asynchronously, pending write dropped, all channels DIRECT after release.
